// File: rtl/proc_ctrl_seq_pkg.sv
// Shared state codes, opcode/funct encodings, ALU codes and the decoded-control payload
// for the proc_ctrl_seq sequencer.
package proc_ctrl_seq_pkg;

  localparam int unsigned OP_W       = 6;
  localparam int unsigned ALU_CODE_W = 6;
  localparam int unsigned WAIT_W     = 8;

  typedef enum logic [2:0] {
    PROC_FETCH  = 3'd0,
    PROC_DECODE = 3'd1,
    PROC_EXE    = 3'd2,
    PROC_MEM    = 3'd3,
    PROC_WB     = 3'd4,
    PROC_HALT   = 3'd5,
    PROC_ERR    = 3'd6
  } state_t;

  // Opcodes (bits [DATA_WIDTH-1 -: 6])
  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_JMP   = 6'h02;
  localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_SLTI  = 6'h0a;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'h0c;
  localparam logic [OP_W-1:0] OP_ORI   = 6'h0d;
  localparam logic [OP_W-1:0] OP_LUI   = 6'h0f;
  localparam logic [OP_W-1:0] OP_PUSH  = 6'h1b;
  localparam logic [OP_W-1:0] OP_POP   = 6'h1c;
  localparam logic [OP_W-1:0] OP_MULI  = 6'h1d;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2b;

  // R-type funct codes (bits [5:0])
  localparam logic [5:0] FN_SLL = 6'h01;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2a;
  localparam logic [5:0] FN_MUL = 6'h2c;

  // ALU operation codes
  localparam logic [ALU_CODE_W-1:0] ALU_NOP = 6'h00;
  localparam logic [ALU_CODE_W-1:0] ALU_ADD = 6'h01;
  localparam logic [ALU_CODE_W-1:0] ALU_SUB = 6'h02;
  localparam logic [ALU_CODE_W-1:0] ALU_MUL = 6'h03;
  localparam logic [ALU_CODE_W-1:0] ALU_SRL = 6'h04;
  localparam logic [ALU_CODE_W-1:0] ALU_SLL = 6'h05;
  localparam logic [ALU_CODE_W-1:0] ALU_AND = 6'h06;
  localparam logic [ALU_CODE_W-1:0] ALU_OR  = 6'h07;
  localparam logic [ALU_CODE_W-1:0] ALU_NOR = 6'h08;
  localparam logic [ALU_CODE_W-1:0] ALU_SLT = 6'h09;

  typedef enum logic [1:0] {
    BR_NONE = 2'd0,
    BR_JUMP = 2'd1,
    BR_BEQ  = 2'd2,
    BR_BNE  = 2'd3
  } br_kind_t;

  typedef struct packed {
    logic [ALU_CODE_W-1:0] alu_oprn;
    logic                  is_mem;
    logic                  mem_rd;
    logic                  rf_wr;
    br_kind_t              br_kind;
    logic                  illegal;
  } ctrl_dec_t;

  // Opcodes that need a MEM phase
  function automatic logic is_mem_op(input logic [OP_W-1:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_PUSH) || (op == OP_POP);
  endfunction

endpackage

// File: rtl/proc_ctrl_seq_decode.sv
// Combinational instruction decoder: opcode/funct -> ALU code, memory class,
// register write-back, branch kind and illegal flag.
module ctrl_decode
  import proc_ctrl_seq_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] instruction,
  output ctrl_dec_t             dec
);

  logic [OP_W-1:0] opcode;
  logic [5:0]      funct;
  logic            unused_fields;

  assign opcode        = instruction[DATA_WIDTH-1 -: OP_W];
  assign funct         = instruction[5:0];
  assign unused_fields = ^instruction[DATA_WIDTH-OP_W-1:6];

  // Unknown encodings decode to a NOP with the illegal flag set
  always_comb begin
    dec        = '0;
    dec.is_mem = is_mem_op(opcode);
    case (opcode)
      OP_RTYPE: begin
        dec.rf_wr = 1'b1;
        case (funct)
          FN_ADD:  dec.alu_oprn = ALU_ADD;
          FN_SUB:  dec.alu_oprn = ALU_SUB;
          FN_MUL:  dec.alu_oprn = ALU_MUL;
          FN_SRL:  dec.alu_oprn = ALU_SRL;
          FN_SLL:  dec.alu_oprn = ALU_SLL;
          FN_AND:  dec.alu_oprn = ALU_AND;
          FN_OR:   dec.alu_oprn = ALU_OR;
          FN_NOR:  dec.alu_oprn = ALU_NOR;
          FN_SLT:  dec.alu_oprn = ALU_SLT;
          FN_JR: begin
            dec.rf_wr   = 1'b0;
            dec.br_kind = BR_JUMP;
          end
          default: begin
            dec.rf_wr   = 1'b0;
            dec.illegal = 1'b1;
          end
        endcase
      end
      OP_ADDI: begin dec.alu_oprn = ALU_ADD; dec.rf_wr = 1'b1; end
      OP_MULI: begin dec.alu_oprn = ALU_MUL; dec.rf_wr = 1'b1; end
      OP_ANDI: begin dec.alu_oprn = ALU_AND; dec.rf_wr = 1'b1; end
      OP_ORI:  begin dec.alu_oprn = ALU_OR;  dec.rf_wr = 1'b1; end
      OP_SLTI: begin dec.alu_oprn = ALU_SLT; dec.rf_wr = 1'b1; end
      OP_LUI:  dec.rf_wr = 1'b1;
      OP_BEQ:  begin dec.alu_oprn = ALU_SUB; dec.br_kind = BR_BEQ; end
      OP_BNE:  begin dec.alu_oprn = ALU_SUB; dec.br_kind = BR_BNE; end
      OP_LW:   begin dec.alu_oprn = ALU_ADD; dec.mem_rd = 1'b1; dec.rf_wr = 1'b1; end
      OP_SW:   dec.alu_oprn = ALU_ADD;
      OP_PUSH: dec.rf_wr = 1'b0;
      OP_POP:  begin dec.mem_rd = 1'b1; dec.rf_wr = 1'b1; end
      OP_JMP:  dec.br_kind = BR_JUMP;
      OP_JAL:  begin dec.br_kind = BR_JUMP; dec.rf_wr = 1'b1; end
      default: dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/proc_ctrl_seq.sv
// FETCH/DECODE/EXE/MEM/WB processor sequencer with memory-stall timeout and halt support.
// Optional performance counters are built only when CTRL_PERF_CNT_EN is defined.
module proc_ctrl_seq
  import proc_ctrl_seq_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ALU_OPRN_WIDTH = 6,
  parameter int unsigned MEM_WAIT_MAX   = 15,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [DATA_WIDTH-1:0]     INSTRUCTION,
  input  logic                      ZERO,
  input  logic                      MEM_READY,
  input  logic                      HALT_REQ,
  output logic [2:0]                STATE,
  output logic                      READ,
  output logic                      WRITE,
  output logic                      IR_LOAD,
  output logic                      RF_READ,
  output logic                      RF_WRITE,
  output logic [ALU_OPRN_WIDTH-1:0] ALU_OPRN,
  output logic                      PC_INC,
  output logic                      PC_LOAD,
  output logic                      ILLEGAL,
  output logic                      MEM_ERR,
  output logic [CNT_WIDTH-1:0]      INSTR_CNT,
  output logic [CNT_WIDTH-1:0]      STALL_CNT
);

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT_MAX - 1);

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              mem_err_q, mem_err_d;
  logic              stall_c, retire_c, timeout_c, pc_load_c;
  ctrl_dec_t         dec;

  ctrl_decode #(.DATA_WIDTH(DATA_WIDTH)) u_decode (
    .instruction (INSTRUCTION),
    .dec         (dec)
  );

  assign timeout_c = (wait_q == WAIT_LAST);
  assign STATE     = state_q;
  assign MEM_ERR   = mem_err_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= PROC_FETCH;
      wait_q    <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      mem_err_q <= mem_err_d;
    end
  end

  always_comb begin
    case (dec.br_kind)
      BR_JUMP: pc_load_c = 1'b1;
      BR_BEQ:  pc_load_c = ZERO;
      BR_BNE:  pc_load_c = ~ZERO;
      default: pc_load_c = 1'b0;
    endcase
  end

  // Next state and strobes; strobes are forced low combinationally while RST is asserted
  always_comb begin
    state_d   = PROC_FETCH;
    wait_d    = '0;
    mem_err_d = mem_err_q;
    stall_c   = 1'b0;
    retire_c  = 1'b0;
    READ      = 1'b0;
    WRITE     = 1'b0;
    IR_LOAD   = 1'b0;
    RF_READ   = 1'b0;
    RF_WRITE  = 1'b0;
    ALU_OPRN  = '0;
    PC_INC    = 1'b0;
    PC_LOAD   = 1'b0;
    ILLEGAL   = 1'b0;
    if (RST) begin
      case (state_q)
        PROC_FETCH: begin
          READ = 1'b1;
          if (MEM_READY) begin
            IR_LOAD = 1'b1;
            state_d = PROC_DECODE;
          end else begin
            stall_c = 1'b1;
            if (timeout_c) begin
              state_d   = PROC_ERR;
              mem_err_d = 1'b1;
            end else begin
              state_d = PROC_FETCH;
              wait_d  = wait_q + WAIT_W'(1);
            end
          end
        end
        PROC_DECODE: begin
          RF_READ = 1'b1;
          ILLEGAL = dec.illegal;
          state_d = PROC_EXE;
        end
        PROC_EXE: begin
          ALU_OPRN = ALU_OPRN_WIDTH'(dec.alu_oprn);
          state_d  = dec.is_mem ? PROC_MEM : PROC_WB;
        end
        PROC_MEM: begin
          READ  = dec.mem_rd;
          WRITE = ~dec.mem_rd;
          if (MEM_READY) begin
            state_d = PROC_WB;
          end else begin
            stall_c = 1'b1;
            if (timeout_c) begin
              state_d   = PROC_ERR;
              mem_err_d = 1'b1;
            end else begin
              state_d = PROC_MEM;
              wait_d  = wait_q + WAIT_W'(1);
            end
          end
        end
        PROC_WB: begin
          RF_WRITE = dec.rf_wr;
          PC_LOAD  = pc_load_c;
          PC_INC   = ~pc_load_c;
          retire_c = 1'b1;
          state_d  = HALT_REQ ? PROC_HALT : PROC_FETCH;
        end
        PROC_HALT: state_d = HALT_REQ ? PROC_HALT : PROC_FETCH;
        PROC_ERR:  state_d = PROC_ERR;
        default:   state_d = PROC_FETCH;
      endcase
    end
  end

`ifdef CTRL_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] instr_cnt_q, stall_cnt_q;

  // Free-running, wrapping retirement and stall counters
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      instr_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (retire_c) instr_cnt_q <= instr_cnt_q + CNT_WIDTH'(1);
      if (stall_c)  stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
    end
  end

  assign INSTR_CNT = instr_cnt_q;
  assign STALL_CNT = stall_cnt_q;
`else
  logic unused_perf;
  assign unused_perf = retire_c | stall_c;
  assign INSTR_CNT   = '0;
  assign STALL_CNT   = '0;
`endif

endmodule

// File: tb/tb_proc_ctrl_seq.sv
// Scoreboard bench for proc_ctrl_seq: per-instruction transactions expand into per-cycle
// stimulus and expected outputs; a monitor compares the DUT each cycle.
`timescale 1ns/1ps
module tb_proc_ctrl_seq;

  localparam int unsigned DW     = 32;
  localparam int unsigned AW     = 6;
  localparam int unsigned MAXW   = 15;
  localparam int unsigned CW     = 16;
  localparam int unsigned N_RAND = 300;

  localparam logic [7:0] SB_RD  = 8'h80;
  localparam logic [7:0] SB_WR  = 8'h40;
  localparam logic [7:0] SB_IRL = 8'h20;
  localparam logic [7:0] SB_RFR = 8'h10;
  localparam logic [7:0] SB_RFW = 8'h08;
  localparam logic [7:0] SB_PCI = 8'h04;
  localparam logic [7:0] SB_PCL = 8'h02;
  localparam logic [7:0] SB_ILL = 8'h01;

  localparam logic [2:0] ST_FETCH = 3'd0;
  localparam logic [2:0] ST_DEC   = 3'd1;
  localparam logic [2:0] ST_EXE   = 3'd2;
  localparam logic [2:0] ST_MEM   = 3'd3;
  localparam logic [2:0] ST_WB    = 3'd4;
  localparam logic [2:0] ST_HALT  = 3'd5;
  localparam logic [2:0] ST_ERR   = 3'd6;

`ifdef CTRL_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic          CLK, RST, ZERO, MEM_READY, HALT_REQ;
  logic [DW-1:0] INSTRUCTION;
  logic [2:0]    STATE;
  logic          READ, WRITE, IR_LOAD, RF_READ, RF_WRITE, PC_INC, PC_LOAD, ILLEGAL, MEM_ERR;
  logic [AW-1:0] ALU_OPRN;
  logic [CW-1:0] INSTR_CNT, STALL_CNT;

  proc_ctrl_seq #(
    .DATA_WIDTH(DW), .ALU_OPRN_WIDTH(AW), .MEM_WAIT_MAX(MAXW), .CNT_WIDTH(CW)
  ) dut (
    .CLK(CLK), .RST(RST), .INSTRUCTION(INSTRUCTION), .ZERO(ZERO), .MEM_READY(MEM_READY),
    .HALT_REQ(HALT_REQ), .STATE(STATE), .READ(READ), .WRITE(WRITE), .IR_LOAD(IR_LOAD),
    .RF_READ(RF_READ), .RF_WRITE(RF_WRITE), .ALU_OPRN(ALU_OPRN), .PC_INC(PC_INC),
    .PC_LOAD(PC_LOAD), .ILLEGAL(ILLEGAL), .MEM_ERR(MEM_ERR), .INSTR_CNT(INSTR_CNT),
    .STALL_CNT(STALL_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // br: 0 none, 1 unconditional, 2 beq, 3 bne
  typedef struct { logic [5:0] op; logic [5:0] fn; logic [5:0] alu; bit rd; bit wr; bit rfw; int br; } kind_t;
  typedef struct { logic rst; logic ready; logic halt; logic zero; logic [DW-1:0] instr; } stim_t;
  typedef struct { logic [2:0] st; logic [7:0] strb; logic [5:0] alu; logic merr; logic [CW-1:0] icnt; logic [CW-1:0] scnt; } exp_t;

  kind_t       kinds[$];
  stim_t       stim_q[$];
  exp_t        exp_q[$];
  logic [DW-1:0] g_instr;
  logic [CW-1:0] m_icnt, m_scnt;
  logic          m_merr;
  int unsigned   n_checks, n_fail, n_driven, n_checked;

  function automatic void add_kind(input logic [5:0] op, input logic [5:0] fn, input logic [5:0] alu,
                                   input bit rd, input bit wr, input bit rfw, input int br);
    kind_t k;
    k.op = op; k.fn = fn; k.alu = alu; k.rd = rd; k.wr = wr; k.rfw = rfw; k.br = br;
    kinds.push_back(k);
  endfunction

  function automatic int find_kind(input logic [5:0] op, input logic [5:0] fn);
    foreach (kinds[i])
      if (kinds[i].op == op && (op != 6'h00 || kinds[i].fn == fn)) return i;
    return -1;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(1, 0));
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, n_checked, got, expv);
    end
  endtask

  task automatic emit(input logic rst, input logic ready, input logic halt, input logic zero,
                      input logic [2:0] st, input logic [7:0] strb, input logic [5:0] alu);
    stim_t s;
    exp_t  e;
    s = '{rst, ready, halt, zero, g_instr};
    e = '{st, strb, alu, m_merr, m_icnt, m_scnt};
    stim_q.push_back(s);
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    m_icnt = '0; m_scnt = '0; m_merr = 1'b0;
    emit(1'b0, rb(), rb(), rb(), ST_FETCH, 8'h00, 6'h00);
  endtask

  // n cycles of MEM_READY low; reaching the wait limit ends in ERR and a reset
  task automatic stall_cycles(input int n, input logic [2:0] st, input logic [7:0] strb, output bit to);
    to = (n >= int'(MAXW));
    for (int i = 0; i < (to ? int'(MAXW) : n); i++) begin
      emit(1'b1, 1'b0, rb(), rb(), st, strb, 6'h00);
      m_scnt++;
    end
    if (to) begin
      m_merr = 1'b1;
      repeat ($urandom_range(3, 1)) emit(1'b1, rb(), rb(), rb(), ST_ERR, 8'h00, 6'h00);
      do_reset();
    end
  endtask

  task automatic run_instr(input logic [31:0] instr, input int fs, input int ms, input int hl,
                           input int zf, input bit abort_mem);
    int k;
    bit to, rd, wr, rfw, ill;
    int br;
    logic [5:0] alu;
    logic [7:0] mstrb, wb;
    logic z, taken;
    k   = find_kind(instr[31:26], instr[5:0]);
    ill = (k < 0);
    if (ill) begin alu = '0; rd = 0; wr = 0; rfw = 0; br = 0; end
    else begin alu = kinds[k].alu; rd = kinds[k].rd; wr = kinds[k].wr; rfw = kinds[k].rfw; br = kinds[k].br; end
    g_instr = instr;
    stall_cycles(fs, ST_FETCH, SB_RD, to);
    if (to) return;
    emit(1'b1, 1'b1, rb(), rb(), ST_FETCH, SB_RD | SB_IRL, 6'h00);
    emit(1'b1, rb(), rb(), rb(), ST_DEC, SB_RFR | (ill ? SB_ILL : 8'h00), 6'h00);
    emit(1'b1, rb(), rb(), rb(), ST_EXE, 8'h00, alu);
    if (rd || wr) begin
      mstrb = rd ? SB_RD : SB_WR;
      if (abort_mem) begin
        for (int i = 0; i < ms; i++) begin
          emit(1'b1, 1'b0, rb(), rb(), ST_MEM, mstrb, 6'h00);
          m_scnt++;
        end
        do_reset();
        return;
      end
      stall_cycles(ms, ST_MEM, mstrb, to);
      if (to) return;
      emit(1'b1, 1'b1, rb(), rb(), ST_MEM, mstrb, 6'h00);
    end
    z     = (zf < 0) ? rb() : 1'(zf);
    taken = (br == 1) || (br == 2 && z) || (br == 3 && !z);
    wb    = (rfw ? SB_RFW : 8'h00) | (taken ? SB_PCL : SB_PCI);
    emit(1'b1, rb(), 1'(hl > 0), z, ST_WB, wb, 6'h00);
    m_icnt++;
    if (hl > 0) begin
      for (int i = 0; i < hl - 1; i++) emit(1'b1, rb(), 1'b1, rb(), ST_HALT, 8'h00, 6'h00);
      emit(1'b1, rb(), 1'b0, rb(), ST_HALT, 8'h00, 6'h00);
    end
  endtask

  function automatic int pick_stall();
    int r;
    r = int'($urandom_range(99, 0));
    if (r < 60) return 0;
    if (r < 90) return int'($urandom_range(3, 1));
    if (r < 97) return int'(MAXW) - 1;
    return int'(MAXW);
  endfunction

  // Driver: applies one stimulus record per cycle just after the rising edge
  initial begin
    stim_t s;
    RST = 1'b0; ZERO = 1'b0; MEM_READY = 1'b0; HALT_REQ = 1'b0; INSTRUCTION = '0;
    forever begin
      @(posedge CLK);
      #1;
      if (stim_q.size() > 0) begin
        s = stim_q.pop_front();
        RST = s.rst; MEM_READY = s.ready; HALT_REQ = s.halt; ZERO = s.zero; INSTRUCTION = s.instr;
        n_driven++;
      end
    end
  end

  // Monitor: compares DUT outputs against the scoreboard on the falling edge
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (n_checked < n_driven && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("state", 32'(STATE), 32'(e.st));
        check("strobes", 32'({READ, WRITE, IR_LOAD, RF_READ, RF_WRITE, PC_INC, PC_LOAD, ILLEGAL}), 32'(e.strb));
        check("alu_oprn", 32'(ALU_OPRN), 32'(e.alu));
        check("mem_err", 32'(MEM_ERR), 32'(e.merr));
        check("instr_cnt", 32'(INSTR_CNT), PERF ? 32'(e.icnt) : 32'd0);
        check("stall_cnt", 32'(STALL_CNT), PERF ? 32'(e.scnt) : 32'd0);
        n_checked++;
      end
    end
  end

  initial begin
    int total;
    logic [31:0] ins;
    int r, fs, ms, hl;
    n_checks = 0; n_fail = 0; n_driven = 0; n_checked = 0;
    m_icnt = '0; m_scnt = '0; m_merr = 1'b0; g_instr = '0;

    add_kind(6'h00, 6'h20, 6'h01, 0, 0, 1, 0); add_kind(6'h00, 6'h22, 6'h02, 0, 0, 1, 0);
    add_kind(6'h00, 6'h2c, 6'h03, 0, 0, 1, 0); add_kind(6'h00, 6'h02, 6'h04, 0, 0, 1, 0);
    add_kind(6'h00, 6'h01, 6'h05, 0, 0, 1, 0); add_kind(6'h00, 6'h24, 6'h06, 0, 0, 1, 0);
    add_kind(6'h00, 6'h25, 6'h07, 0, 0, 1, 0); add_kind(6'h00, 6'h27, 6'h08, 0, 0, 1, 0);
    add_kind(6'h00, 6'h2a, 6'h09, 0, 0, 1, 0); add_kind(6'h00, 6'h08, 6'h00, 0, 0, 0, 1);
    add_kind(6'h08, 6'h00, 6'h01, 0, 0, 1, 0); add_kind(6'h1d, 6'h00, 6'h03, 0, 0, 1, 0);
    add_kind(6'h0c, 6'h00, 6'h06, 0, 0, 1, 0); add_kind(6'h0d, 6'h00, 6'h07, 0, 0, 1, 0);
    add_kind(6'h0a, 6'h00, 6'h09, 0, 0, 1, 0); add_kind(6'h0f, 6'h00, 6'h00, 0, 0, 1, 0);
    add_kind(6'h04, 6'h00, 6'h02, 0, 0, 0, 2); add_kind(6'h05, 6'h00, 6'h02, 0, 0, 0, 3);
    add_kind(6'h23, 6'h00, 6'h01, 1, 0, 1, 0); add_kind(6'h2b, 6'h00, 6'h01, 0, 1, 0, 0);
    add_kind(6'h1b, 6'h00, 6'h00, 0, 1, 0, 0); add_kind(6'h1c, 6'h00, 6'h00, 1, 0, 1, 0);
    add_kind(6'h02, 6'h00, 6'h00, 0, 0, 0, 1); add_kind(6'h03, 6'h00, 6'h00, 0, 0, 1, 1);

    do_reset();
    do_reset();
    run_instr(32'h00221820, 0, 0, 0, -1, 1'b0);          // add
    run_instr(32'h8C220004, 0, 3, 0, -1, 1'b0);          // lw, 3 MEM stalls
    run_instr(32'h10220003, 0, 0, 0, 1, 1'b0);           // beq taken
    run_instr(32'h10220003, 0, 0, 0, 0, 1'b0);           // beq not taken
    run_instr(32'h14220003, 0, 0, 0, 1, 1'b0);           // bne not taken
    run_instr(32'h14220003, 0, 0, 0, 0, 1'b0);           // bne taken
    run_instr(32'h00221820, int'(MAXW), 0, 0, -1, 1'b0); // FETCH timeout
    run_instr(32'h8C220004, int'(MAXW) - 1, int'(MAXW) - 1, 0, -1, 1'b0);
    run_instr(32'h8C220004, 0, int'(MAXW), 0, -1, 1'b0); // MEM timeout
    run_instr(32'h20220005, 0, 0, 3, -1, 1'b0);          // addi then halt
    run_instr(32'hFC000000, 0, 0, 0, -1, 1'b0);          // illegal opcode
    run_instr(32'hAC220000, 1, 2, 0, -1, 1'b1);          // sw reset mid-MEM

    repeat (N_RAND) begin
      ins = $urandom();
      if ($urandom_range(9, 0) < 8) begin
        r = int'($urandom_range(kinds.size() - 1, 0));
        ins[31:26] = kinds[r].op;
        if (kinds[r].op == 6'h00) ins[5:0] = kinds[r].fn;
      end else begin
        do begin
          ins = $urandom();
          if (rb()) ins[31:26] = 6'h00;
        end while (find_kind(ins[31:26], ins[5:0]) >= 0);
      end
      fs = pick_stall();
      ms = pick_stall();
      hl = ($urandom_range(9, 0) == 0) ? int'($urandom_range(3, 1)) : 0;
      run_instr(ins, fs, (ms == int'(MAXW) && rb()) ? 1 : ms, hl, -1, ($urandom_range(49, 0) == 0));
    end

    total = exp_q.size();
    for (int c = 0; c < total + 200 && n_checked < total; c++) @(posedge CLK);
    @(negedge CLK);
    check("drain", n_checked, 32'(total));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
